// File: rtl/inst_queue.sv
// inst_queue: instruction queue between the fetcher and the decode stage.
//
// Holds up to DEPTH fetched instructions together with their halfword PC.
// A branch redirect (flush_i) empties the queue in a single cycle.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1 (push = in_valid_i & in_ready_o, pop = out_valid_o &
// out_ready_i). Valid never depends combinationally on the same side's
// ready, and the head fields stay stable while out_valid_o=1 and
// out_ready_i=0.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   flush_i        synchronous clear of pointers and count
//   in_valid_i     fetcher presents an instruction
//   in_ready_o     queue accepts this cycle (not full and not flushing)
//   in_inst_i      instruction, low halfword first
//   in_len32_i     1 = 32-bit format, 0 = 16-bit
//   in_pc_i        halfword PC of the instruction
//   out_valid_o    head entry valid
//   out_ready_i    decode consumes the head this cycle
//   out_inst_o     head instruction
//   out_len32_o    head format length
//   out_pc_o       head PC
//   out_npc_o      head PC + (len32 ? 2 : 1), wrapping at AW bits
//   count_o        number of entries held
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int IW    = 32,
  parameter int AW    = 25
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [IW-1:0]              in_inst_i,
  input  logic                       in_len32_i,
  input  logic [AW-1:0]              in_pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [IW-1:0]              out_inst_o,
  output logic                       out_len32_o,
  output logic [AW-1:0]              out_pc_o,
  output logic [AW-1:0]              out_npc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] mem_inst  [DEPTH];
  logic          mem_len32 [DEPTH];
  logic [AW-1:0] mem_pc    [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          push;
  logic          pop;
  logic [IW-1:0] store_inst;

  assign in_ready_o  = (count != CW'(DEPTH)) & ~flush_i;
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // 16-bit formats only define the low halfword; the upper bits are
  // stored as zero so decode never sees stale fetch data there.
  assign store_inst = in_len32_i ? in_inst_i
                                 : {{(IW-16){1'b0}}, in_inst_i[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i]  <= '0;
        mem_len32[i] <= 1'b0;
        mem_pc[i]    <= '0;
      end
    end else if (flush_i) begin
      // Storage is left untouched; only the bookkeeping is cleared.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_inst[wr_ptr]  <= store_inst;
        mem_len32[wr_ptr] <= in_len32_i;
        mem_pc[wr_ptr]    <= in_pc_i;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Head is read straight from storage; no output register, no bypass.
  assign out_inst_o  = mem_inst[rd_ptr];
  assign out_len32_o = mem_len32[rd_ptr];
  assign out_pc_o    = mem_pc[rd_ptr];
  assign out_npc_o   = mem_pc[rd_ptr] + (mem_len32[rd_ptr] ? AW'(2) : AW'(1));
  assign count_o     = count;

endmodule
